demod_accumulator: RTL and testbench

Integrating stage between `multiplier_wrapper` and `BRAM_Store`. Consumes the stream of signed ADC×sine products and sums them over each triggered record of a programmed sample count. For every record it emits one scaled, saturated 32-bit result word, and it signals completion after the programmed number of records. This reduces BRAM traffic from one word per sample to one word per record.

---
 rtl/demod_pkg.sv | 15 +
 rtl/acc_shift_sat.sv | 59 +++++
 rtl/demod_accumulator.sv | 153 +++++++++++++++
 tb/tb_demod_accumulator.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demod_pkg.sv
// demod_pkg
// Shared definitions for the demodulation accumulator: controller state
// encoding and the default counter / result widths.
package demod_pkg;

  localparam int DEMOD_CNT_WIDTH = 24;
  localparam int DEMOD_OUT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } demod_state_t;

endpackage

// File: rtl/acc_shift_sat.sv
// acc_shift_sat
// Combinational scaling of a wide signed record sum down to a 32-bit result:
// arithmetic right shift by OUT_SHIFT (floor rounding) followed by clamping
// to the signed 32-bit range.
//
// Ports
//   acc_in   in  ACC_WIDTH  signed record sum
//   sat_out  out 32         shifted and clamped result
//   clamped  out 1          high when the shifted value did not fit in 32 bits
module acc_shift_sat
  import demod_pkg::*;
#(
  parameter int ACC_WIDTH = 56,
  parameter int OUT_SHIFT = 16
) (
  input  logic signed [ACC_WIDTH-1:0]       acc_in,
  output logic signed [DEMOD_OUT_WIDTH-1:0] sat_out,
  output logic                              clamped
);

  localparam int OW = DEMOD_OUT_WIDTH;

  // >>> on a signed operand shifts in copies of the sign bit, which is
  // exactly floor division by 2^OUT_SHIFT.
  function automatic logic signed [ACC_WIDTH-1:0] shift_floor(
    input logic signed [ACC_WIDTH-1:0] v
  );
    return v >>> OUT_SHIFT;
  endfunction

  // The value fits in OW bits when every bit from the top down to the OW
  // sign position is identical.
  function automatic logic fits_out(input logic signed [ACC_WIDTH-1:0] v);
    logic [ACC_WIDTH-OW:0] hi;
    hi = v[ACC_WIDTH-1:OW-1];
    return (&hi) || (~|hi);
  endfunction

  function automatic logic signed [OW-1:0] sat32(
    input logic signed [ACC_WIDTH-1:0] v
  );
    if (fits_out(v)) begin
      return v[OW-1:0];
    end else if (v[ACC_WIDTH-1]) begin
      return {1'b1, {(OW-1){1'b0}}};
    end else begin
      return {1'b0, {(OW-1){1'b1}}};
    end
  endfunction

  logic signed [ACC_WIDTH-1:0] shifted;

  always_comb begin
    shifted = shift_floor(acc_in);
    sat_out = sat32(shifted);
    clamped = !fits_out(shifted);
  end

endmodule

// File: rtl/demod_accumulator.sv
// demod_accumulator
// Integrates signed ADC x sine products over triggered records. Each record
// of num_samples valid products yields one scaled, saturated 32-bit word;
// after num_records records the acquisition completes with a done pulse.
//
// Ports
//   clk            in  1          system clock, rising edge
//   rst            in  1          asynchronous active-high reset
//   arm            in  1          start / restart pulse, latches the counts
//   num_samples    in  CNT_WIDTH  products per record
//   num_records    in  CNT_WIDTH  records per acquisition
//   product_in     in  DATA_WIDTH signed product
//   product_valid  in  1          qualifies product_in
//   sum_out        out 32         signed scaled record sum (held)
//   sum_valid      out 1          one-cycle strobe for sum_out
//   busy           out 1          acquisition in progress
//   done           out 1          one-cycle pulse at acquisition end
//   overflow       out 1          sticky: an emitted result was clamped
module demod_accumulator
  import demod_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 56,
  parameter int CNT_WIDTH  = DEMOD_CNT_WIDTH,
  parameter int OUT_SHIFT  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              arm,
  input  logic [CNT_WIDTH-1:0]              num_samples,
  input  logic [CNT_WIDTH-1:0]              num_records,
  input  logic signed [DATA_WIDTH-1:0]      product_in,
  input  logic                              product_valid,
  output logic signed [DEMOD_OUT_WIDTH-1:0] sum_out,
  output logic                              sum_valid,
  output logic                              busy,
  output logic                              done,
  output logic                              overflow
);

  demod_state_t state_q, state_d;

  logic [CNT_WIDTH-1:0]        num_samples_q, num_records_q;
  logic [CNT_WIDTH-1:0]        sample_idx, record_idx;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] product_ext;
  logic signed [ACC_WIDTH-1:0] final_sum;

  logic                              counts_ok;
  logic                              last_sample;
  logic                              last_record;
  logic                              accept;
  logic                              emit;
  logic signed [DEMOD_OUT_WIDTH-1:0] sat_value;
  logic                              clamped;

  always_comb begin
    counts_ok   = (num_samples != '0) && (num_records != '0);
    last_sample = (sample_idx == num_samples_q - CNT_WIDTH'(1));
    last_record = (record_idx == num_records_q - CNT_WIDTH'(1));
    product_ext = ACC_WIDTH'(product_in);
    // The closing sample is folded in here so the record result is available
    // in the same cycle the sample arrives, keeping records back-to-back.
    final_sum   = acc + product_ext;
  end

  acc_shift_sat #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_shift_sat (
    .acc_in  (final_sum),
    .sat_out (sat_value),
    .clamped (clamped)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; arm has priority everywhere and restarts the acquisition
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d = counts_ok ? ACCUM : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (arm) begin
          state_d = counts_ok ? ACCUM : DONE;
        end else if (product_valid && last_sample && last_record) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / qualifier logic
  always_comb begin
    busy   = (state_q == ACCUM);
    accept = (state_q == ACCUM) && !arm && product_valid;
    emit   = accept && last_sample;
  end

  // Stage p0: accumulate, emit record result, strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_samples_q <= '0;
      num_records_q <= '0;
      sample_idx    <= '0;
      record_idx    <= '0;
      acc           <= '0;
      sum_out       <= '0;
      sum_valid     <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      sum_valid <= emit;
      // done lines up with the final sum_valid, and with the cycle after a
      // zero-count arm.
      done      <= (state_d == DONE);
      if (arm) begin
        num_samples_q <= num_samples;
        num_records_q <= num_records;
        sample_idx    <= '0;
        record_idx    <= '0;
        acc           <= '0;
        overflow      <= 1'b0;
      end else if (accept) begin
        if (last_sample) begin
          acc        <= '0;
          sample_idx <= '0;
          record_idx <= record_idx + CNT_WIDTH'(1);
          sum_out    <= sat_value;
          overflow   <= overflow | clamped;
        end else begin
          acc        <= final_sum;
          sample_idx <= sample_idx + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_demod_accumulator.sv
// tb_demod_accumulator
// Drives two accumulators (OUT_SHIFT 0 and 16) from the same stimulus and
// compares every cycle against a record-level reference model, plus directed
// checks of the documented scenarios.
module tb_demod_accumulator;

  localparam int DW = 32;
  localparam int AW = 56;
  localparam int CW = 24;
  localparam longint SMAX = 64'sh7FFF_FFFF;
  localparam longint SMIN = -SMAX - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 arm = 1'b0;
  logic                 product_valid = 1'b0;
  logic [CW-1:0]        num_samples = '0;
  logic [CW-1:0]        num_records = '0;
  logic signed [DW-1:0] product_in = '0;

  logic signed [31:0] sum_out0, sum_out16;
  logic sv0, sv16, busy0, busy16, done0, done16, ovf0, ovf16;

  always #5 clk = ~clk;

  demod_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW), .OUT_SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .arm(arm), .num_samples(num_samples), .num_records(num_records),
    .product_in(product_in), .product_valid(product_valid), .sum_out(sum_out0),
    .sum_valid(sv0), .busy(busy0), .done(done0), .overflow(ovf0));

  demod_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .CNT_WIDTH(CW), .OUT_SHIFT(16)) dut16 (
    .clk(clk), .rst(rst), .arm(arm), .num_samples(num_samples), .num_records(num_records),
    .product_in(product_in), .product_valid(product_valid), .sum_out(sum_out16),
    .sum_valid(sv16), .busy(busy16), .done(done16), .overflow(ovf16));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model (record level) ----------------
  function automatic longint clamp32(input longint v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  function automatic bit clips(input longint v);
    return (v > SMAX) || (v < SMIN);
  endfunction

  longint rec[$];
  int     m_ns, m_nr, m_recs;
  bit     m_active;
  longint tot;
  longint e_sum0 = 0, e_sum16 = 0;
  bit     e_sv = 0, e_done = 0, e_busy = 0, e_ovf0 = 0, e_ovf16 = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rec.delete();
      m_active = 0; m_recs = 0; m_ns = 0; m_nr = 0;
      e_sum0 = 0; e_sum16 = 0; e_sv = 0; e_done = 0; e_busy = 0; e_ovf0 = 0; e_ovf16 = 0;
    end else begin
      e_sv = 0;
      e_done = 0;
      if (arm) begin
        m_ns = int'(num_samples);
        m_nr = int'(num_records);
        m_recs = 0;
        rec.delete();
        e_ovf0 = 0;
        e_ovf16 = 0;
        m_active = (m_ns != 0) && (m_nr != 0);
        if (!m_active) e_done = 1;
      end else if (m_active && product_valid) begin
        rec.push_back(longint'(product_in));
        if (rec.size() == m_ns) begin
          tot = 0;
          foreach (rec[i]) tot += rec[i];
          e_sum0  = clamp32(tot);
          e_ovf0  = e_ovf0 | clips(tot);
          e_sum16 = clamp32(tot >>> 16);
          e_ovf16 = e_ovf16 | clips(tot >>> 16);
          e_sv = 1;
          rec.delete();
          m_recs++;
          if (m_recs == m_nr) begin
            m_active = 0;
            e_done = 1;
          end
        end
      end
      e_busy = m_active;
    end
  end

  // ---------------- per-cycle comparison and capture ----------------
  longint cap0[$];
  longint cap16[$];
  int     n_done0 = 0;

  always @(negedge clk) begin
    chk("sum_valid0", sv0, e_sv);
    chk("sum_valid16", sv16, e_sv);
    chk("done0", done0, e_done);
    chk("done16", done16, e_done);
    chk("busy0", busy0, e_busy);
    chk("busy16", busy16, e_busy);
    chk("overflow0", ovf0, e_ovf0);
    chk("overflow16", ovf16, e_ovf16);
    chk("sum_out0", sum_out0, e_sum0);
    chk("sum_out16", sum_out16, e_sum16);
    if (sv0) cap0.push_back(sum_out0);
    if (sv16) cap16.push_back(sum_out16);
    if (done0) n_done0++;
  end

  function automatic longint at0(input int i);
    return (i < cap0.size()) ? cap0[i] : 64'sh7FFF_0BAD_0BAD;
  endfunction

  function automatic longint at16(input int i);
    return (i < cap16.size()) ? cap16[i] : 64'sh7FFF_0BAD_0BAD;
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input bit a, input bit v, input longint p);
    @(posedge clk);
    #1;
    arm = a;
    product_valid = v;
    product_in = DW'(p);
  endtask

  task automatic do_arm(input int ns, input int nr);
    @(posedge clk);
    #1;
    num_samples = CW'(ns);
    num_records = CW'(nr);
    arm = 1'b1;
    product_valid = 1'b0;
  endtask

  task automatic send(input longint p, input int gap_max);
    repeat ($urandom_range(gap_max, 0)) step(0, 0, 0);
    step(0, 1, p);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0);
  endtask

  int base0, base16, nd;
  int ns, nr;
  longint p;
  longint gap_vals[6] = '{-5, 7, -9, 1, 1, 1};

  initial begin
    #12;
    chk("rst_sum_out", sum_out0, 0);
    chk("rst_sum_valid", sv0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_overflow", ovf0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // basic record
    base0 = cap0.size(); nd = n_done0;
    do_arm(4, 1);
    send(10, 0); send(20, 0); send(30, 0); send(40, 0);
    idle(3);
    chk("basic_strobes", cap0.size() - base0, 1);
    chk("basic_sum", at0(base0), 100);
    chk("basic_done", n_done0 - nd, 1);

    // gapped, two records, negative values
    base0 = cap0.size(); nd = n_done0;
    do_arm(3, 2);
    foreach (gap_vals[i]) send(gap_vals[i], 2);
    idle(3);
    chk("gap_strobes", cap0.size() - base0, 2);
    chk("gap_sum_a", at0(base0), -7);
    chk("gap_sum_b", at0(base0 + 1), 3);
    chk("gap_done", n_done0 - nd, 1);

    // back-to-back single-sample records with floor rounding
    base16 = cap16.size();
    do_arm(1, 5);
    repeat (5) send(64'h0001_8000, 0);
    idle(2);
    chk("b2b_strobes", cap16.size() - base16, 5);
    for (int i = 0; i < 5; i++) chk("b2b_sum", at16(base16 + i), 1);
    base16 = cap16.size();
    do_arm(1, 1);
    send(-1, 0);
    idle(2);
    chk("floor_neg", at16(base16), -1);

    // saturation and sticky overflow
    base0 = cap0.size();
    do_arm(2, 1);
    send(64'h7FFF_FFFF, 0); send(64'h7FFF_FFFF, 0);
    idle(3);
    chk("sat_sum", at0(base0), SMAX);
    chk("sat_overflow", ovf0, 1);
    idle(3);
    chk("sat_sticky", ovf0, 1);
    do_arm(1, 1);
    step(0, 0, 0);
    chk("sat_cleared", ovf0, 0);
    send(1, 0);
    idle(2);

    // abort after two samples; re-arm coincident with a discarded product
    base0 = cap0.size();
    do_arm(4, 1);
    send(100, 0); send(200, 0);
    @(posedge clk);
    #1;
    num_samples = 4; num_records = 1;
    arm = 1'b1; product_valid = 1'b1; product_in = 1000;
    send(1, 0); send(2, 0); send(3, 0); send(4, 0);
    idle(3);
    chk("abort_strobes", cap0.size() - base0, 1);
    chk("abort_sum", at0(base0), 10);

    // zero counts
    base0 = cap0.size(); nd = n_done0;
    do_arm(5, 0);
    send(9, 0);
    idle(2);
    do_arm(0, 3);
    send(9, 0);
    idle(2);
    chk("zero_strobes", cap0.size() - base0, 0);
    chk("zero_done", n_done0 - nd, 2);

    // randomized acquisitions with occasional aborts and extreme values
    for (int t = 0; t < 40; t++) begin
      ns = $urandom_range(4, 1);
      nr = $urandom_range(3, 1);
      do_arm(ns, nr);
      for (int k = 0; k < ns * nr; k++) begin
        if ($urandom_range(29, 0) == 0) do_arm(ns, nr);
        case ($urandom_range(3, 0))
          0: p = SMAX;
          1: p = SMIN;
          default: p = longint'($signed($urandom));
        endcase
        send(p, 2);
      end
      idle($urandom_range(2, 0));
    end
    idle(3);

    // asynchronous reset mid-record
    do_arm(4, 2);
    send(5, 0); send(6, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy0, 0);
    chk("arst_sum_out0", sum_out0, 0);
    chk("arst_sum_out16", sum_out16, 0);
    chk("arst_sum_valid", sv0, 0);
    chk("arst_done", done0, 0);
    chk("arst_overflow", ovf0, 0);
    #4 rst = 1'b0;
    base0 = cap0.size(); nd = n_done0;
    repeat (6) send(7, 0);
    idle(3);
    chk("arst_no_strobe", cap0.size() - base0, 0);
    chk("arst_no_done", n_done0 - nd, 0);
    chk("arst_idle_busy", busy0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
